// File: rtl/uart_pkg.sv
// UART receive shared types.
// State encoding and frame width used by the byte receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte buffer.
// Power-of-two depth, occupancy counter, push/pop in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_en = pop && !empty;
  // a pop frees the slot this push needs, even when full
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with synchronizer and output FIFO.
// Mid-bit sampling; framing and overrun reported as single pulses.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_frame,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t state, nstate;

  logic                      sync1, sync2, sync_q;
  logic                      rx_bit, fall;
  logic [CW-1:0]             baud_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      sample, stop_ok, stop_bad;
  logic                      pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      unused_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync1  <= rx_serial;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  assign rx_bit = sync2;
  // a line held low after a bad stop never yields a new edge
  assign fall   = sync_q & ~sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (fall) nstate = START;
      START: if (sample) nstate = rx_bit ? IDLE : DATA;
      DATA:  if (sample && bit_cnt == BW'(UART_DATA_BITS - 1))
               nstate = STOP;
      STOP:  if (sample) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    sample = 1'b0;
    unique case (state)
      START:      sample = baud_cnt == HALF_T;
      DATA, STOP: sample = baud_cnt == FULL_T;
      default:    sample = 1'b0;
    endcase
    stop_ok  = state == STOP && sample && rx_bit;
    stop_bad = state == STOP && sample && !rx_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (state == IDLE || sample) baud_cnt <= '0;
      else                         baud_cnt <= baud_cnt + 1'b1;
      if (state == IDLE)
        bit_cnt <= '0;
      else if (state == DATA && sample)
        bit_cnt <= bit_cnt + 1'b1;
      if (state == DATA && sample)
        shift <= {rx_bit, shift[UART_DATA_BITS-1:1]};
      framing_err <= stop_bad;
      overrun_err <= stop_ok && fifo_full && !pop;
    end
  end

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stop_ok),
    .pop   (pop),
    .din   (shift),
    .dout  (rx_frame),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scenario bench for uart_byte_rx at 16 clocks per bit.
// A queue model of the byte stream and FIFO supplies expected results.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int BIT = 16;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_frame;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       framing_err;
  logic       overrun_err;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] got[$];

  uart_byte_rx #(
    .CLKS_PER_BIT (BIT),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .rx_frame    (rx_frame),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_frame);
      if (framing_err) fe_cnt = fe_cnt + 1;
      if (overrun_err) oe_cnt = oe_cnt + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int gap_bits);
    rx_serial = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      tick(BIT);
    end
    rx_serial = stop;
    tick(BIT);
    rx_serial = 1'b1;
    tick(gap_bits * BIT);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(DEP + 4);
    rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", rx_valid);
    end
    checks++;
    if (rx_frame !== 8'h00) begin
      errors++; $display("FAIL reset_frame got %h exp 00", rx_frame);
    end
    checks++;
    if (framing_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got fe=%b oe=%b exp 0 0",
               framing_err, overrun_err);
    end
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_single();
    int fe0 = fe_cnt;
    int oe0 = oe_cnt;
    int n0 = got.size();
    fork
      send_byte(8'hA5, 1'b1, 0);
      begin
        tick(146);
        checks++;
        if (rx_valid !== 1'b0) begin
          errors++; $display("FAIL single_early got valid=%b exp 0", rx_valid);
        end
      end
    join
    tick(4);
    checks++;
    if (rx_valid !== 1'b1 || rx_frame !== 8'hA5) begin
      errors++;
      $display("FAIL single_byte got v=%b d=%h exp 1 a5", rx_valid, rx_frame);
    end
    checks++;
    if (fe_cnt != fe0 || oe_cnt != oe0) begin
      errors++;
      $display("FAIL single_err got fe=%0d oe=%0d exp 0 0",
               fe_cnt - fe0, oe_cnt - oe0);
    end
    drain();
    checks++;
    if (got.size() != n0 + 1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got n=%0d v=%b exp 1 0",
               got.size() - n0, rx_valid);
    end else if (got[n0] !== 8'hA5) begin
      errors++; $display("FAIL single_pop got %h exp a5", got[n0]);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] model[$];
    int exp_oe = 0;
    int oe0 = oe_cnt;
    int n0 = got.size();
    bit stable = 1'b1;
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, 1);
      if (model.size() < DEP) model.push_back(8'(i));
      else exp_oe++;
      if (i == 4) begin
        checks++;
        if (oe_cnt != oe0) begin
          errors++; $display("FAIL overrun_early got %0d exp 0", oe_cnt - oe0);
        end
      end
    end
    checks++;
    if (oe_cnt - oe0 != exp_oe) begin
      errors++;
      $display("FAIL overrun_pulse got %0d exp %0d", oe_cnt - oe0, exp_oe);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_frame !== model[0] || rx_valid !== 1'b1) stable = 1'b0;
    end
    tick(1);
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL overrun_hold got %h exp %h", rx_frame, model[0]);
    end
    drain();
    checks++;
    if (got.size() - n0 != model.size()) begin
      errors++;
      $display("FAIL overrun_count got %0d exp %0d",
               got.size() - n0, model.size());
    end else begin
      for (int i = 0; i < model.size(); i++) begin
        checks++;
        if (got[n0+i] !== model[i]) begin
          errors++;
          $display("FAIL overrun_order[%0d] got %h exp %h",
                   i, got[n0+i], model[i]);
        end
      end
    end
  endtask

  task automatic test_framing();
    int fe0 = fe_cnt;
    int n0 = got.size();
    send_byte(8'h3C, 1'b0, 1);
    checks++;
    if (fe_cnt - fe0 != 1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL framing_pulse got fe=%0d v=%b exp 1 0",
               fe_cnt - fe0, rx_valid);
    end
    send_byte(8'h7E, 1'b1, 1);
    drain();
    checks++;
    if (got.size() != n0 + 1 || fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL framing_next got n=%0d fe=%0d exp 1 1",
               got.size() - n0, fe_cnt - fe0);
    end else if (got[n0] !== 8'h7E) begin
      errors++; $display("FAIL framing_next got %h exp 7e", got[n0]);
    end
  endtask

  task automatic test_break();
    int fe0 = fe_cnt;
    int n0 = got.size();
    rx_serial = 1'b0;
    tick(40 * BIT);
    rx_serial = 1'b1;
    tick(2 * BIT);
    checks++;
    if (fe_cnt - fe0 != 1 || got.size() != n0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL break_once got fe=%0d v=%b exp 1 0",
               fe_cnt - fe0, rx_valid);
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    int oe0 = oe_cnt;
    rx_serial = 1'b0;
    tick(4);
    rx_serial = 1'b1;
    tick(11);
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL glitch_idle got %0d exp %0d", dut.state, IDLE);
    end
    tick(2 * BIT);
    checks++;
    if (rx_valid !== 1'b0 || fe_cnt != fe0 || oe_cnt != oe0) begin
      errors++;
      $display("FAIL glitch_quiet got v=%b fe=%0d oe=%0d exp 0 0 0",
               rx_valid, fe_cnt - fe0, oe_cnt - oe0);
    end
  endtask

  task automatic test_stream();
    logic [7:0] pkt[4] = '{8'hFF, 8'h12, 8'h34, 8'h56};
    int oe0 = oe_cnt;
    int n0 = got.size();
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(pkt[i], 1'b1, (i == 3) ? 1 : 0);
    rx_ready = 1'b0;
    checks++;
    if (got.size() - n0 != 4 || oe_cnt != oe0) begin
      errors++;
      $display("FAIL stream_count got n=%0d oe=%0d exp 4 0",
               got.size() - n0, oe_cnt - oe0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[n0+i] !== pkt[i]) begin
          errors++;
          $display("FAIL stream[%0d] got %h exp %h", i, got[n0+i], pkt[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[3];
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      send_byte(b[i], 1'b1, 1);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (i < 3 && (rx_valid !== 1'b1 || rx_frame !== b[i])) begin
        errors++;
        $display("FAIL b2b[%0d] got v=%b d=%h exp 1 %h",
                 i, rx_valid, rx_frame, b[i]);
      end else if (i == 3 && rx_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_empty got v=%b exp 0", rx_valid);
      end
    end
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       stop;
    int nbad = 0;
    int fe0 = fe_cnt;
    int oe0 = oe_cnt;
    int n0 = got.size();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          b = 8'($urandom);
          stop = $urandom_range(0, 3) != 0;
          send_byte(b, stop, $urandom_range(1, 3));
          if (stop) exp_q.push_back(b);
          else nbad++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    drain();
    checks++;
    if (fe_cnt - fe0 != nbad || oe_cnt != oe0) begin
      errors++;
      $display("FAIL random_err got fe=%0d oe=%0d exp %0d 0",
               fe_cnt - fe0, oe_cnt - oe0, nbad);
    end
    checks++;
    if (got.size() - n0 != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d exp %0d",
               got.size() - n0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (got[n0+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random[%0d] got %h exp %h", i, got[n0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    rx_ready = 1'b0;
    send_byte(8'h5A, 1'b1, 1);
    fork
      send_byte(8'h99, 1'b1, 0);
      begin
        tick(5 * BIT + 8);
        rst = 1'b0;
        tick(2);
        checks++;
        if (rx_valid !== 1'b0 || rx_frame !== 8'h00 ||
            framing_err !== 1'b0 || overrun_err !== 1'b0) begin
          errors++;
          $display("FAIL midreset_out got v=%b d=%h fe=%b oe=%b exp 0 00 0 0",
                   rx_valid, rx_frame, framing_err, overrun_err);
        end
      end
    join
    tick(4);
    rst = 1'b1;
    n0 = got.size();
    tick(2 * BIT);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_idle got v=%b exp 0", rx_valid);
    end
    send_byte(8'h42, 1'b1, 1);
    drain();
    checks++;
    if (got.size() != n0 + 1) begin
      errors++;
      $display("FAIL midreset_count got %0d exp 1", got.size() - n0);
    end else if (got[n0] !== 8'h42) begin
      errors++; $display("FAIL midreset_byte got %h exp 42", got[n0]);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_overrun();
    test_framing();
    test_break();
    test_glitch();
    test_stream();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output byte buffer depth; power of two, 2..16.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port rx_frame  output  8  byte at FIFO head, feeding the packet handler.
REQ-007 The block SHALL have port rx_valid  output  1  FIFO non-empty; rx_frame is valid.
REQ-008 The block SHALL have port rx_ready  input  1  consumer accepts; a pop occurs on a clk edge with rx_valid && rx_ready.
REQ-009 The block SHALL have port framing_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port overrun_err  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.

Function
REQ-011 rx_serial SHALL pass through a 2-flop synchronizer; all decisions use the second flop (2-cycle input latency).
REQ-012 The receive FSM SHALL have states IDLE, START, DATA, STOP.
REQ-013 IDLE->START on a synchronized high-to-low transition; the bit counter clears.
REQ-014 START SHALL sample at CLKS_PER_BIT/2 (integer divide) cycles after the edge; low -> DATA; high -> IDLE (glitch rejected, no error, no byte).
REQ-015 DATA SHALL sample every CLKS_PER_BIT cycles, 8 samples, shifting LSB first into an 8-bit register; after the 8th sample -> STOP.
REQ-016 STOP SHALL sample once after CLKS_PER_BIT cycles; high -> push byte (if FIFO not full) and return to IDLE; low -> pulse framing_err, discard byte, return to IDLE.
REQ-017 After a low stop bit, IDLE SHALL wait until the line samples high before accepting a new start edge (break condition produces one framing_err only).
REQ-018 The baud counter SHALL be width $clog2(CLKS_PER_BIT) and SHALL reset to 0 on every sample point and on every IDLE->START transition.
REQ-019 The FIFO push SHALL occur on the clk edge of the valid stop sample; rx_valid SHALL assert on the next cycle (first-word fall-through).
REQ-020 rx_frame SHALL be stable while rx_valid && !rx_ready.
REQ-021 With the FIFO full at push time, the new byte SHALL be dropped, stored bytes kept, and overrun_err pulsed.
REQ-022 A simultaneous push and pop SHALL both take effect and leave the occupancy unchanged, including at full (no overrun) and empty.
REQ-023 Occupancy SHALL use a counter of width $clog2(FIFO_DEPTH)+1; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 rx_valid SHALL remain high across back-to-back pops until the FIFO is empty; there is no dead cycle between bytes.

Reset
REQ-025 While rst is low: FSM=IDLE, synchronizer flops=1, counters/pointers=0, rx_valid=0, rx_frame=0x00, framing_err=0, overrun_err=0.
REQ-026 Reset asserted mid-byte SHALL abandon the byte; after release, the block SHALL not push until a fresh start edge.
REQ-027 After release, the first possible start detection SHALL be 2 cycles later (synchronizer refill).

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum (rx_state_t) and UART_DATA_BITS=8.
REQ-029 The FIFO SHALL be sub-module byte_fifo (parameters DEPTH, WIDTH=8; push, pop, full, empty, count); the FSM and synchronizer stay in uart_byte_rx.

Verification
REQ-030 With CLKS_PER_BIT=16, send 0xA5 with a good stop bit -> rx_valid rises after the stop sample, rx_frame=0xA5, no error pulses.
REQ-031 Hold rx_ready=0 and send 5 bytes 0x01..0x05 (FIFO_DEPTH=4) -> one overrun_err pulse on byte 5; popping then yields 0x01,0x02,0x03,0x04.
REQ-032 Send a 0x3C frame with the stop bit low -> one framing_err pulse, rx_valid stays 0; next good byte 0x7E is received correctly.
REQ-033 Drive a 4-cycle low glitch on idle rx_serial -> no byte, no error, FSM back in IDLE before CLKS_PER_BIT cycles.
REQ-034 With rx_ready=1, stream 0xFF,0x12,0x34,0x56 (a packet-handler kill/ID frame) -> all 4 bytes delivered in order, no overrun.
REQ-035 Assert rst during bit 4 of 0x99, then release and send 0x42 -> only 0x42 appears, and outputs are at reset values during reset.
